pipe_rca: RTL and testbench
===========================

PIPE_RCA -- requirements
Module: pipe_rca

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; SHALL be a multiple of SEG.
REQ-002 Parameter: SEG, 8, segment width added per pipeline stage; STAGES = WIDTH/SEG, STAGES >= 1.
REQ-003 Port: clk  input  1  sole clock, all state on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operand set present.
REQ-006 Port: in_ready  output  1  block accepts operands this cycle.
REQ-007 Port: a, b  input  WIDTH each  operands.
REQ-008 Port: cin  input  1  carry-in (add mode only).
REQ-009 Port: sub  input  1  0 = a+b+cin, 1 = a-b.
REQ-010 Port: out_valid  output  1  result present.
REQ-011 Port: out_ready  input  1  downstream accepts result.
REQ-012 Port: sum  output  WIDTH  result; cout  output  1  carry out of MSB.
REQ-013 Port: ovf  output  1  signed overflow; present only with PIPE_RCA_OVF_EN.

Function
REQ-014 Stage k (0..STAGES-1) SHALL add segment k of a and b' plus the carry registered by stage k-1; stage 0 uses the effective carry-in.
REQ-015 sub=1: b' = ~b, effective carry-in = 1, cin ignored; sub=0: b' = b, carry-in = cin.
REQ-016 Operand segments above k SHALL be delayed (skewed) and completed sum segments below k SHALL be carried forward, so that one transaction moves through the stages as a unit.
REQ-017 Latency: result valid exactly STAGES cycles after acceptance with no stall; one transaction per cycle throughput.
REQ-018 Acceptance: transaction accepted when in_valid && in_ready at a rising edge.
REQ-019 Global advance enable adv = !out_valid || out_ready; in_ready = adv.
REQ-020 adv=0: all stage registers, sum, cout, ovf, out_valid SHALL hold unchanged.
REQ-021 in_valid=0 while adv=1 inserts a bubble; bubbles SHALL never assert out_valid.
REQ-022 cout = carry out of bit WIDTH-1 (sub: 1 = no borrow).
REQ-023 sum, cout SHALL be stable while out_valid=1 && out_ready=0.
REQ-024 Simultaneous output handshake and input acceptance SHALL both occur in the same cycle with no loss.
REQ-025 STAGES=1 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-026 rst=1 at a rising edge: all stage valids, out_valid, sum, cout, ovf SHALL become 0.
REQ-027 Reset mid-operation SHALL discard all in-flight transactions; no partial result ever appears.
REQ-028 in_ready SHALL be 1 in the first cycle after reset deassertion.

Configuration
REQ-029 Macro PIPE_RCA_OVF_EN defined: ovf port exists; ovf = carry into MSB XOR carry out of MSB, aligned with sum, reset 0, held under stall.
REQ-030 Macro undefined: no ovf port, no overflow logic; all other behaviour identical.

Verification (WIDTH=32, SEG=8 unless stated)
REQ-031 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x00000000, cout=1, out_valid=1 for one cycle.
REQ-032 a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=7, b=5, sub=1 -> sum=0x00000002, cout=1.
REQ-033 OVF_EN: a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, ovf=1, cout=0; a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1.
REQ-034 Three back-to-back ops (1+1, 2+2, 3+3), out_ready low for 2 cycles when first result appears -> in_ready low during stall, sum held at 2, results 2, 4, 6 delivered in order, none lost or duplicated.
REQ-035 rst pulsed 2 cycles after accepting two ops -> out_valid stays 0 for the following 6 cycles; next op 10+20 returns 30 after 4 cycles.
REQ-036 WIDTH=16, SEG=4: a=0x0FFF, b=0x0001 -> sum=0x1000, cout=0 after 4 cycles; WIDTH=8, SEG=8: latency 1.

Source files
------------

// File: rtl/pipe_rca.sv
// Segmented ripple-carry adder/subtractor, one SEG-bit segment per stage.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, a, b, cin, sub
// in; out_valid/out_ready, sum, cout out; ovf only with PIPE_RCA_OVF_EN.
// Parameters: WIDTH (multiple of SEG), SEG; STAGES = WIDTH/SEG.
module pipe_rca #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPE_RCA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    // Per-stage registers: skewed operands, partial sum, carry, valid
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];

    // Stage inputs (stage 0 from ports, stage k from register k-1)
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic             c_src [STAGES];
    logic             v_src [STAGES];

    // Stage next-state
    logic [SEG:0]     seg_r [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_d   [STAGES];

    logic adv;

    // Whole pipe moves together; it only stops when a result is blocked
    assign adv      = !v_q[LAST] || out_ready;
    assign in_ready = adv;

    always_comb begin
        // Subtract as a + ~b + 1; cin only matters when adding
        a_src[0] = a;
        b_src[0] = sub ? ~b : b;
        s_src[0] = '0;
        c_src[0] = sub | cin;
        v_src[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
            v_src[k] = v_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg_r[k] = {1'b0, a_src[k][k*SEG +: SEG]}
                     + {1'b0, b_src[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, c_src[k]};
            s_d[k]   = s_src[k];
            s_d[k][k*SEG +: SEG] = seg_r[k][SEG-1:0];
            c_d[k]   = seg_r[k][SEG];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                v_q[k] <= v_src[k];
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];

`ifdef PIPE_RCA_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Carry into the MSB is recovered as a ^ b' ^ sum at that bit
    assign ovf_d = c_d[LAST]
                 ^ a_src[LAST][WIDTH-1]
                 ^ b_src[LAST][WIDTH-1]
                 ^ s_d[LAST][WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_rca.sv
// Scoreboard bench for pipe_rca (32/8 main, plus 16/4 and 8/8 checks).
// Expected results are queued at acceptance and popped on output handshake.
module tb_pipe_rca;

    localparam int W  = 32;
    localparam int SG = 8;
    localparam int ST = W / SG;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
`ifdef PIPE_RCA_OVF_EN
    logic         ovf;
    logic         ovf16;
    logic         ovf8;
`endif

    pipe_rca #(.WIDTH(W), .SEG(SG)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum),
`ifdef PIPE_RCA_OVF_EN
        .ovf(ovf),
`endif
        .cout(cout)
    );

    logic        iv16 = 1'b0, ir16, ov16, c16, or16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0, s16;
    pipe_rca #(.WIDTH(16), .SEG(4)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(1'b0), .sub(1'b0),
        .out_valid(ov16), .out_ready(or16),
        .sum(s16),
`ifdef PIPE_RCA_OVF_EN
        .ovf(ovf16),
`endif
        .cout(c16)
    );

    logic       iv8 = 1'b0, ir8, ov8, c8, or8 = 1'b1;
    logic [7:0] a8 = '0, b8 = '0, s8;
    pipe_rca #(.WIDTH(8), .SEG(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(1'b0), .sub(1'b0),
        .out_valid(ov8), .out_ready(or8),
        .sum(s8),
`ifdef PIPE_RCA_OVF_EN
        .ovf(ovf8),
`endif
        .cout(c8)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        logic [W:0] r;
        exp_t       e;
        if (s) r = {1'b0, x} - {1'b0, y};
        else   r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.s = r[W-1:0];
        e.c = s ? ~r[W] : r[W];
        if (s) e.o = (x[W-1] != y[W-1]) && (e.s[W-1] != x[W-1]);
        else   e.o = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
        return e;
    endfunction

    // Monitor: push on input handshake, pop on output handshake, hold check
    logic [W-1:0] held_s;
    logic         held_c;
    bit           stalled = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stalled = 1'b0;
        end else begin
            if (in_valid && in_ready)
                q.push_back(model(a, b, cin, sub));
            if (stalled && out_valid) begin
                check("hold_sum", sum, held_s);
                check("hold_cout", cout, held_c);
            end
            stalled = out_valid && !out_ready;
            held_s  = sum;
            held_c  = cout;
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("sum", sum, e.s);
                    check("cout", cout, e.c);
`ifdef PIPE_RCA_OVF_EN
                    check("ovf", ovf, e.o);
`endif
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic ts);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = ta; b = tb_; cin = tc; sub = ts;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 64'(n < 50), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
`ifdef PIPE_RCA_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // Full carry ripple, latency, single-cycle valid
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        wait_valid(n);
        check("lat_main", n, ST);
        check("ripple_sum", sum, 32'h0);
        check("ripple_cout", cout, 1);
        @(negedge clk);
        check("valid_once", out_valid, 0);
        @(posedge clk); #1;

        // Subtract, cin ignored when subtracting, overflow corners
        send(32'd5, 32'd7, 1'b0, 1'b1);
        send(32'd7, 32'd5, 1'b1, 1'b1);
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
        send(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0);
        drain();

        // Stall with back-to-back ops
        @(posedge clk); #1;
        send(32'd1, 32'd1, 1'b0, 1'b0);
        send(32'd2, 32'd2, 1'b0, 1'b0);
        send(32'd3, 32'd3, 1'b0, 1'b0);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("stall1_valid", out_valid, 1);
        check("stall1_rdy", in_ready, 0);
        check("stall1_sum", sum, 32'd2);
        @(negedge clk);
        check("stall2_rdy", in_ready, 0);
        check("stall2_sum", sum, 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Reset mid-flight discards everything
        @(posedge clk); #1;
        send(32'd100, 32'd1, 1'b0, 1'b0);
        send(32'd200, 32'd2, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_flush", out_valid, 0);
        end
        @(posedge clk); #1;
        send(32'd10, 32'd20, 1'b0, 1'b0);
        wait_valid(n);
        check("lat_post_rst", n, ST);
        check("post_rst_sum", sum, 32'd30);
        drain();

        // Random stream with bubbles and random backpressure
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send($urandom, $urandom, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
            end
            begin
                for (int i = 0; i < 80; i++) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // WIDTH=16, SEG=4
        @(posedge clk); #1;
        a16 = 16'h0FFF; b16 = 16'h0001; iv16 = 1'b1;
        check("w16_ready", ir16, 1);
        @(posedge clk); #1;
        iv16 = 1'b0;
        n = 1;
        @(negedge clk);
        while (!ov16 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w16_lat", n, 4);
        check("w16_sum", s16, 16'h1000);
        check("w16_cout", c16, 0);

        // WIDTH=8, SEG=8: plain registered adder
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'h01; iv8 = 1'b1;
        check("w8_ready", ir8, 1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        n = 1;
        @(negedge clk);
        while (!ov8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w8_lat", n, 1);
        check("w8_sum", s8, 8'h00);
        check("w8_cout", c8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
